// File: rtl/demux_scan_sequencer.sv
// Sweeps a 1:16 demux select through a sampled channel mask, dwelling DWELL cycles
// on each enabled channel in ascending order, and routes din to the selected output.
module demux_scan_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        loop,
  input  logic [15:0] ch_mask,
  input  logic        din,
  output logic [3:0]  sel,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_DWELL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [15:0]        mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         ptr_q, ptr_d;

  logic [3:0]         seek_sel;
  logic               seek_found;
  logic [15:0]        mask_clr;

  // ptr is one bit wider than sel so that sel+1 after channel 15 never matches channel 0.
  always_comb begin
    seek_sel   = sel_q;
    seek_found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!seek_found && mask_q[i] && (5'(i) >= ptr_q)) begin
        seek_sel   = 4'(i);
        seek_found = 1'b1;
      end
    end
  end

  assign mask_clr = mask_q & ~(16'(1) << sel_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (abort) begin
      state_d = S_IDLE;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_d  = ch_mask;
            ptr_d   = '0;
            state_d = (ch_mask == '0) ? S_DONE : S_SEEK;
          end
        end
        S_SEEK: begin
          sel_d   = seek_sel;
          cnt_d   = CNT_W'(DWELL - 1);
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            mask_d = mask_clr;
            if (mask_clr == '0) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = {1'b0, sel_q} + 5'd1;
              state_d = S_SEEK;
            end
          end
        end
        S_DONE: begin
          if (loop) begin
            mask_d  = ch_mask;
            ptr_d   = '0;
            state_d = (ch_mask == '0) ? S_DONE : S_SEEK;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel  = sel_q;
  assign dout = (state_q == S_DWELL) ? ({15'b0, din} << sel_q) : 16'h0000;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench for demux_scan_sequencer (DWELL=4): sweep order, dwell length,
// empty mask, loop re-sampling, ignored start, abort, din tracking and async reset.
module tb_demux_scan_sequencer;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, loop, din;
  logic [15:0] ch_mask;
  logic [3:0]  sel;
  logic [15:0] dout;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  demux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
    .ch_mask(ch_mask), .din(din), .sel(sel), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_sel, input logic [15:0] e_dout,
                            input logic e_busy, input logic e_done);
    check({tag, ".sel"},  {12'h0, sel},  {12'h0, e_sel});
    check({tag, ".dout"}, dout,          e_dout);
    check({tag, ".busy"}, {15'h0, busy}, {15'h0, e_busy});
    check({tag, ".done"}, {15'h0, done}, {15'h0, e_done});
  endtask

  // Four DWELL cycles on one channel with din held high.
  task automatic dwell_ch(input string tag, input logic [3:0] ch);
    for (int k = 0; k < DWELL; k++) begin
      tick();
      check_outs(tag, ch, 16'(1) << ch, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0; din = 1'b1; ch_mask = 16'h0000;
    #12;
    check_outs("reset", 4'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_outs("idle", 4'd0, 16'h0000, 1'b0, 1'b0);

    // Mask 8421: channels 0,5,10,15 in order; mask change mid-sweep has no effect.
    ch_mask = 16'h8421; start = 1'b1;
    tick(); start = 1'b0;
    check_outs("s2.seek0", 4'd0, 16'h0000, 1'b1, 1'b0);
    ch_mask = 16'hFFFF;
    dwell_ch("s2.ch0", 4'd0);
    tick(); check_outs("s2.seek5", 4'd0, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s2.ch5", 4'd5);
    tick(); check_outs("s2.seek10", 4'd5, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s2.ch10", 4'd10);
    tick(); check_outs("s2.seek15", 4'd10, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s2.ch15", 4'd15);
    tick(); check_outs("s2.done", 4'd15, 16'h0000, 1'b1, 1'b1);
    tick(); check_outs("s2.idle", 4'd15, 16'h0000, 1'b0, 1'b0);

    // Empty mask: straight to DONE, then IDLE.
    ch_mask = 16'h0000; start = 1'b1;
    tick(); start = 1'b0;
    check_outs("s3.done", 4'd15, 16'h0000, 1'b1, 1'b1);
    tick(); check_outs("s3.idle", 4'd15, 16'h0000, 1'b0, 1'b0);

    // Loop held: sweep 0081, then re-sampled mask 0082; a mid-sweep start is ignored.
    ch_mask = 16'h0081; loop = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check_outs("s4.seek0", 4'd15, 16'h0000, 1'b1, 1'b0);
    ch_mask = 16'h0082;
    tick(); check_outs("s4.ch0a", 4'd0, 16'h0001, 1'b1, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    check_outs("s4.ch0b", 4'd0, 16'h0001, 1'b1, 1'b0);
    tick(); tick();
    check_outs("s4.ch0d", 4'd0, 16'h0001, 1'b1, 1'b0);
    tick(); check_outs("s4.seek7", 4'd0, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s4.ch7", 4'd7);
    tick(); check_outs("s4.done1", 4'd7, 16'h0000, 1'b1, 1'b1);
    tick(); check_outs("s4.seek1", 4'd7, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s4.ch1", 4'd1);
    tick(); check_outs("s4.seek7b", 4'd1, 16'h0000, 1'b1, 1'b0);
    dwell_ch("s4.ch7b", 4'd7);
    tick(); check_outs("s4.done2", 4'd7, 16'h0000, 1'b1, 1'b1);
    loop = 1'b0;
    tick(); check_outs("s4.idle", 4'd7, 16'h0000, 1'b0, 1'b0);

    // Abort during DWELL on channel 5: IDLE, sel held, no done; restart from channel 0.
    ch_mask = 16'h0021; start = 1'b1;
    tick(); start = 1'b0;
    dwell_ch("s5.ch0", 4'd0);
    tick();
    tick(); check_outs("s5.ch5", 4'd5, 16'h0020, 1'b1, 1'b0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check_outs("s5.abort", 4'd5, 16'h0000, 1'b0, 1'b0);
    tick(); check_outs("s5.quiet", 4'd5, 16'h0000, 1'b0, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    check_outs("s5.seek", 4'd5, 16'h0000, 1'b1, 1'b0);
    tick(); check_outs("s5.restart", 4'd0, 16'h0001, 1'b1, 1'b0);
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0;
    check_outs("s5.prio", 4'd0, 16'h0000, 1'b0, 1'b0);

    // din toggled on channel 7: only dout[7] follows it.
    ch_mask = 16'h0080; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < DWELL; k++) begin
      tick();
      din = 1'b1; #1; check("s6.din1", dout, 16'h0080);
      din = 1'b0; #1; check("s6.din0", dout, 16'h0000);
    end
    din = 1'b1;
    tick(); check_outs("s6.done", 4'd7, 16'h0000, 1'b1, 1'b1);
    tick();

    // Asynchronous reset mid-DWELL.
    ch_mask = 16'h0010; start = 1'b1;
    tick(); start = 1'b0;
    tick(); check_outs("s1.ch4", 4'd4, 16'h0010, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("s1.rst", 4'd0, 16'h0000, 1'b0, 1'b0);
    tick(); rst_n = 1'b1;
    tick(); check_outs("s1.after", 4'd0, 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
